// File: rtl/nabp_image_reader_pkg.sv
// ============================================================================
// nabp_image_reader_pkg : shared types and derived constants for the image
//                         RAM read/write addressers.   Rev 1.0
// ============================================================================
`default_nettype none

package nabp_image_reader_pkg;

  localparam int IMAGE_SIZE_DEF       = 120;
  localparam int PARTITION_SIZE_DEF   = 16;
  localparam int NO_OF_PARTITIONS_DEF = 8;

  typedef enum logic [1:0] {
    RD_READY  = 2'd0,
    RD_X_SCAN = 2'd1,
    RD_Y_SCAN = 2'd2,
    RD_DRAIN  = 2'd3
  } reader_state_e;

  typedef enum logic {
    SCAN_X = 1'b0,
    SCAN_Y = 1'b1
  } scan_mode_e;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int LAST_PARTITION_LINES =
    IMAGE_SIZE_DEF - (NO_OF_PARTITIONS_DEF - 1) * PARTITION_SIZE_DEF;
  localparam int BEATS_PER_PASS =
    2 * NO_OF_PARTITIONS_DEF * PARTITION_SIZE_DEF * IMAGE_SIZE_DEF;
  localparam int PART_CNT_WIDTH = cnt_width(NO_OF_PARTITIONS_DEF);
  localparam int LINE_CNT_WIDTH = cnt_width(PARTITION_SIZE_DEF);
  localparam int SCAN_CNT_WIDTH = cnt_width(IMAGE_SIZE_DEF);

endpackage

`default_nettype wire

// File: rtl/nabp_image_reader_if.sv
// ============================================================================
// nabp_image_reader_if : host kick, image RAM read port and PE chain head.
// Optional hs_first_pass under NABP_IMAGE_READER_FIRST_PASS_CLEAR_EN. Rev 1.0
// ============================================================================
`default_nettype none

interface nabp_image_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14
);

  logic                  hs_kick;
`ifdef NABP_IMAGE_READER_FIRST_PASS_CLEAR_EN
  logic                  hs_first_pass;
`endif
  logic                  pe_ready;
  logic                  ir_rd_en;
  logic [ADDR_WIDTH-1:0] ir_rd_addr;
  logic [DATA_WIDTH-1:0] ir_rd_data;
  logic                  pe_valid;
  logic                  pe_pixel_valid;
  logic                  pe_scan_mode;
  logic [DATA_WIDTH-1:0] pe_data;
  logic                  pe_done;
  logic                  busy;

`ifdef NABP_IMAGE_READER_FIRST_PASS_CLEAR_EN
  modport master (
    input  hs_kick, hs_first_pass, pe_ready, ir_rd_data,
    output ir_rd_en, ir_rd_addr, pe_valid, pe_pixel_valid, pe_scan_mode,
           pe_data, pe_done, busy
  );
  modport slave (
    output hs_kick, hs_first_pass, pe_ready, ir_rd_data,
    input  ir_rd_en, ir_rd_addr, pe_valid, pe_pixel_valid, pe_scan_mode,
           pe_data, pe_done, busy
  );
`else
  modport master (
    input  hs_kick, pe_ready, ir_rd_data,
    output ir_rd_en, ir_rd_addr, pe_valid, pe_pixel_valid, pe_scan_mode,
           pe_data, pe_done, busy
  );
  modport slave (
    output hs_kick, pe_ready, ir_rd_data,
    input  ir_rd_en, ir_rd_addr, pe_valid, pe_pixel_valid, pe_scan_mode,
           pe_data, pe_done, busy
  );
`endif

endinterface

`default_nettype wire

// File: rtl/nabp_partition_scan_counter.sv
// ============================================================================
// nabp_partition_scan_counter : partition/line/scan counter nest with wrap
//                               flags, shared by read and write addressers.
//                               Rev 1.0
// ============================================================================
`default_nettype none

module nabp_partition_scan_counter
  import nabp_image_reader_pkg::*;
#(
  parameter int IMAGE_SIZE       = IMAGE_SIZE_DEF,
  parameter int PARTITION_SIZE   = PARTITION_SIZE_DEF,
  parameter int NO_OF_PARTITIONS = NO_OF_PARTITIONS_DEF
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     clear,
  input  logic                                     advance,
  input  logic                                     part_step,
  output logic [cnt_width(NO_OF_PARTITIONS)-1:0]   part,
  output logic [cnt_width(PARTITION_SIZE)-1:0]     line,
  output logic [cnt_width(IMAGE_SIZE)-1:0]         scan,
  output logic                                     scan_wrap,
  output logic                                     line_wrap,
  output logic                                     part_last
);

  localparam int PW = cnt_width(NO_OF_PARTITIONS);
  localparam int LW = cnt_width(PARTITION_SIZE);
  localparam int SW = cnt_width(IMAGE_SIZE);

  assign scan_wrap = (scan == SW'(IMAGE_SIZE - 1));
  assign line_wrap = (line == LW'(PARTITION_SIZE - 1));
  assign part_last = (part == PW'(NO_OF_PARTITIONS - 1));

  // part only advances when the caller says so: the x and y scans of one
  // partition share the same p.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      part <= '0;
      line <= '0;
      scan <= '0;
    end else if (advance) begin
      scan <= scan_wrap ? '0 : scan + SW'(1);
      if (scan_wrap) begin
        line <= line_wrap ? '0 : line + LW'(1);
        if (line_wrap && part_step) begin
          part <= part_last ? '0 : part + PW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/nabp_image_reader.sv
// ============================================================================
// nabp_image_reader : image RAM read addresser and PE-chain data streamer.
// Optional RAM-clear pass under NABP_IMAGE_READER_FIRST_PASS_CLEAR_EN. Rev 1.0
// ============================================================================
`default_nettype none

module nabp_image_reader
  import nabp_image_reader_pkg::*;
#(
  parameter int IMAGE_SIZE       = IMAGE_SIZE_DEF,
  parameter int PARTITION_SIZE   = PARTITION_SIZE_DEF,
  parameter int NO_OF_PARTITIONS = NO_OF_PARTITIONS_DEF,
  parameter int DATA_WIDTH       = 16,
  parameter int ADDR_WIDTH       = $clog2(IMAGE_SIZE * IMAGE_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nabp_image_reader_if.master  bus
);

  localparam logic [1:0] ST_READY  = RD_READY;
  localparam logic [1:0] ST_X_SCAN = RD_X_SCAN;
  localparam logic [1:0] ST_Y_SCAN = RD_Y_SCAN;
  localparam logic [1:0] ST_DRAIN  = RD_DRAIN;

  localparam int PW = cnt_width(NO_OF_PARTITIONS);
  localparam int LW = cnt_width(PARTITION_SIZE);
  localparam int SW = cnt_width(IMAGE_SIZE);
  localparam int RW = cnt_width(NO_OF_PARTITIONS * PARTITION_SIZE) + 1;
  localparam int AW = ADDR_WIDTH;

  logic [1:0]            state;
  logic [AW-1:0]         addr;
  logic [AW-1:0]         x_base;
  logic [AW-1:0]         last_rd_addr;
  logic [RW-1:0]         part_base;
  logic [RW-1:0]         row;
  logic [PW-1:0]         part;
  logic [LW-1:0]         line;
  logic [SW-1:0]         scan;
  logic                  scan_wrap;
  logic                  line_wrap;
  logic                  part_last;
  logic                  line_end;
  logic                  pass_end;
  logic                  kick;
  logic                  issue;
  logic                  in_range;
  logic                  rd_en;
  logic                  first_pass;
  scan_mode_e            cur_mode;
  logic                  beat_valid;
  logic                  beat_pixel;
  scan_mode_e            beat_mode;
  logic                  beat_done;
  logic [DATA_WIDTH-1:0] beat_data;
  logic                  unused_cnt;

  nabp_partition_scan_counter #(
    .IMAGE_SIZE       (IMAGE_SIZE),
    .PARTITION_SIZE   (PARTITION_SIZE),
    .NO_OF_PARTITIONS (NO_OF_PARTITIONS)
  ) u_counter (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (kick),
    .advance   (issue),
    .part_step (state == ST_Y_SCAN),
    .part      (part),
    .line      (line),
    .scan      (scan),
    .scan_wrap (scan_wrap),
    .line_wrap (line_wrap),
    .part_last (part_last)
  );

  // Addresses are tracked incrementally; p and s are only needed as wrap flags.
  assign unused_cnt = ^{part, scan};

  assign kick     = (state == ST_READY) && bus.hs_kick;
  assign issue    = ((state == ST_X_SCAN) || (state == ST_Y_SCAN)) && bus.pe_ready;
  assign cur_mode = (state == ST_Y_SCAN) ? SCAN_Y : SCAN_X;
  assign row      = part_base + RW'(line);
  assign in_range = (row < RW'(IMAGE_SIZE));
  assign line_end = scan_wrap && line_wrap;
  assign pass_end = line_end && part_last && (state == ST_Y_SCAN);
  assign rd_en    = issue && in_range && !first_pass;

`ifdef NABP_IMAGE_READER_FIRST_PASS_CLEAR_EN
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      first_pass <= 1'b0;
    end else if (kick) begin
      first_pass <= bus.hs_first_pass;
    end
  end
`else
  assign first_pass = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= ST_READY;
      addr         <= '0;
      x_base       <= '0;
      part_base    <= '0;
      last_rd_addr <= '0;
      beat_valid   <= 1'b0;
      beat_pixel   <= 1'b0;
      beat_mode    <= SCAN_X;
      beat_done    <= 1'b0;
    end else begin
      beat_valid <= issue;
      beat_pixel <= issue && in_range;
      beat_mode  <= issue ? cur_mode : SCAN_X;
      beat_done  <= issue && pass_end;
      if (rd_en) begin
        last_rd_addr <= addr;
      end
      if (kick) begin
        state     <= ST_X_SCAN;
        addr      <= '0;
        x_base    <= '0;
        part_base <= '0;
      end else if (issue) begin
        if (state == ST_X_SCAN) begin
          // X row end rolls straight into the next row start, so +1 suffices.
          if (line_end) begin
            state <= ST_Y_SCAN;
            addr  <= AW'(part_base);
          end else begin
            addr <= addr + AW'(1);
          end
        end else if (line_end) begin
          if (part_last) begin
            state <= ST_DRAIN;
          end else begin
            state     <= ST_X_SCAN;
            x_base    <= x_base + AW'(PARTITION_SIZE * IMAGE_SIZE);
            addr      <= x_base + AW'(PARTITION_SIZE * IMAGE_SIZE);
            part_base <= part_base + RW'(PARTITION_SIZE);
          end
        end else if (scan_wrap) begin
          addr <= AW'(row + RW'(1));
        end else begin
          addr <= addr + AW'(IMAGE_SIZE);
        end
      end else if (state == ST_DRAIN) begin
        state <= ST_READY;
      end
    end
  end

  assign beat_data = (beat_pixel && !first_pass) ? bus.ir_rd_data : '0;

  assign bus.ir_rd_en       = rd_en;
  assign bus.ir_rd_addr     = rd_en ? addr : last_rd_addr;
  assign bus.pe_valid       = beat_valid;
  assign bus.pe_pixel_valid = beat_pixel;
  assign bus.pe_scan_mode   = beat_mode;
  assign bus.pe_data        = beat_data;
  assign bus.pe_done        = beat_done;
  assign bus.busy           = (state != ST_READY);

endmodule

`default_nettype wire

// File: tb/tb_nabp_image_reader.sv
// ============================================================================
// tb_nabp_image_reader : directed bench, N=6 P=4 K=2, RAM data = address.
// Clear-pass case built when NABP_IMAGE_READER_FIRST_PASS_CLEAR_EN is set.
// ============================================================================
`default_nettype none

module tb_nabp_image_reader;

  localparam int N  = 6;
  localparam int P  = 4;
  localparam int K  = 2;
  localparam int DW = 16;
  localparam int AW = 6;
  localparam int NB = 2 * K * P * N;

  logic clk;
  logic reset_n;

  nabp_image_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  nabp_image_reader #(
    .IMAGE_SIZE       (N),
    .PARTITION_SIZE   (P),
    .NO_OF_PARTITIONS (K),
    .DATA_WIDTH       (DW),
    .ADDR_WIDTH       (AW)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: every location holds its own address, one-cycle read latency.
  always @(posedge clk) begin
    if (bus.ir_rd_en) bus.ir_rd_data <= DW'(bus.ir_rd_addr);
  end

  logic [DW-1:0] beat_data [$];
  bit            beat_pv   [$];
  bit            beat_mode [$];
  bit            beat_done [$];
  logic [AW-1:0] rd_q      [$];

  always @(negedge clk) begin
    if (bus.pe_valid) begin
      beat_data.push_back(bus.pe_data);
      beat_pv.push_back(bus.pe_pixel_valid);
      beat_mode.push_back(bus.pe_scan_mode);
      beat_done.push_back(bus.pe_done);
    end
    if (bus.ir_rd_en) rd_q.push_back(bus.ir_rd_addr);
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  int exp_addr [NB];
  bit exp_pv   [NB];
  bit exp_mode [NB];

  task automatic clear_logs();
    beat_data.delete();
    beat_pv.delete();
    beat_mode.delete();
    beat_done.delete();
    rd_q.delete();
  endtask

  task automatic kick();
    @(posedge clk); #1;
    bus.hs_kick = 1'b1;
    @(posedge clk); #1;
    bus.hs_kick = 1'b0;
  endtask

  task automatic run_pass(input string tag, input bit stall, input bit extra_kick,
                          input bit clr, input bit spot);
    bit done_seen = 1'b0;
    bit stalled   = 1'b0;
    bit kicked    = 1'b0;
    int cyc = 0;
    int n0, errs, npv, ndone, j;
    int exp_d;
    clear_logs();
    kick();
    check({tag, "_lat_rden"}, 32'(bus.ir_rd_en), clr ? 32'd0 : 32'd1);
    check({tag, "_lat_addr"}, 32'(bus.ir_rd_addr), 32'd0);
    check({tag, "_lat_nobeat"}, 32'(bus.pe_valid), 32'd0);
    @(posedge clk); #1;
    check({tag, "_lat_beat"}, 32'(bus.pe_valid), 32'd1);
    while (!done_seen && cyc < 400) begin
      if (bus.pe_done) begin
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd1);
        check({tag, "_valid_at_done"}, 32'(bus.pe_valid), 32'd1);
        done_seen = 1'b1;
      end else begin
        if (kicked) bus.hs_kick = 1'b0;
        if (extra_kick && !kicked && beat_data.size() >= 10) begin
          bus.hs_kick = 1'b1;
          kicked = 1'b1;
        end
        if (stall && !stalled && beat_data.size() >= 30) begin
          bus.pe_ready = 1'b0;
          n0 = beat_data.size();
          repeat (5) @(posedge clk);
          #1;
          check({tag, "_stall_trail"}, 32'(beat_data.size() - n0), 32'd1);
          bus.pe_ready = 1'b1;
          stalled = 1'b1;
        end
        @(posedge clk); #1;
        cyc++;
      end
    end
    bus.hs_kick = 1'b0;
    check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
    @(posedge clk); #1;
    check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);

    check({tag, "_beats"}, 32'(beat_data.size()), 32'(NB));
    errs = 0; npv = 0; ndone = 0;
    for (int i = 0; i < beat_data.size() && i < NB; i++) begin
      exp_d = (exp_pv[i] && !clr) ? exp_addr[i] : 0;
      if (32'(beat_data[i]) != 32'(exp_d) || beat_pv[i] != exp_pv[i] ||
          beat_mode[i] != exp_mode[i]) errs++;
      if (beat_pv[i]) npv++;
      if (beat_done[i]) ndone++;
    end
    check({tag, "_beat_seq_errs"}, 32'(errs), 32'd0);
    check({tag, "_pixel_valid_cnt"}, 32'(npv), 32'd72);
    check({tag, "_done_cnt"}, 32'(ndone), 32'd1);
    if (beat_done.size() > 0)
      check({tag, "_done_last"}, 32'(beat_done[beat_done.size()-1]), 32'd1);
    check({tag, "_rd_cnt"}, 32'(rd_q.size()), clr ? 32'd0 : 32'd72);
    errs = 0; j = 0;
    for (int i = 0; i < NB; i++) begin
      if (exp_pv[i]) begin
        if (j < rd_q.size() && 32'(rd_q[j]) != 32'(exp_addr[i])) errs++;
        j++;
      end
    end
    check({tag, "_rd_seq_errs"}, 32'(errs), 32'd0);
    if (spot && rd_q.size() == 72) begin
      check("spot_p0x_last",  32'(rd_q[23]), 32'd23);
      check("spot_p0y_first", 32'(rd_q[24]), 32'd0);
      check("spot_p0y_2nd",   32'(rd_q[25]), 32'd6);
      check("spot_p0y_l1",    32'(rd_q[30]), 32'd1);
      check("spot_p1x_first", 32'(rd_q[48]), 32'd24);
      check("spot_p1x_last",  32'(rd_q[59]), 32'd35);
      check("spot_p1y_first", 32'(rd_q[60]), 32'd4);
      check("spot_p1y_2nd",   32'(rd_q[61]), 32'd10);
      check("spot_p1y_l1",    32'(rd_q[66]), 32'd5);
      check("spot_p1y_last",  32'(rd_q[71]), 32'd35);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, row, n0, cyc;
    idx = 0;
    for (int p = 0; p < K; p++)
      for (int m = 0; m < 2; m++)
        for (int l = 0; l < P; l++)
          for (int s = 0; s < N; s++) begin
            row = p * P + l;
            exp_addr[idx] = (m == 1) ? (s * N + row) : (row * N + s);
            exp_pv[idx]   = (row < N);
            exp_mode[idx] = (m == 1);
            idx++;
          end

    reset_n      = 1'b0;
    bus.hs_kick  = 1'b0;
    bus.pe_ready = 1'b1;
`ifdef NABP_IMAGE_READER_FIRST_PASS_CLEAR_EN
    bus.hs_first_pass = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_flags", 32'({bus.ir_rd_en, bus.pe_valid, bus.pe_pixel_valid,
                            bus.pe_scan_mode, bus.pe_done, bus.busy}), 32'd0);
    check("rst_addr", 32'(bus.ir_rd_addr), 32'd0);
    check("rst_data", 32'(bus.pe_data), 32'd0);
    reset_n = 1'b1;

    run_pass("full",  1'b0, 1'b0, 1'b0, 1'b1);
    run_pass("stall", 1'b1, 1'b0, 1'b0, 1'b0);
    run_pass("kick2", 1'b0, 1'b1, 1'b0, 1'b0);

    clear_logs();
    kick();
    cyc = 0;
    while (beat_data.size() < 40 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("rst_mid_reach40", 32'(beat_data.size() >= 40), 32'd1);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_flags", 32'({bus.ir_rd_en, bus.pe_valid, bus.pe_pixel_valid,
                                bus.pe_scan_mode, bus.pe_done, bus.busy}), 32'd0);
    check("rst_mid_data", 32'(bus.pe_data), 32'd0);
    reset_n = 1'b1;
    n0 = beat_data.size();
    @(posedge clk); #1;
    check("rst_mid_quiet", 32'(beat_data.size() - n0), 32'd0);
    run_pass("restart", 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef NABP_IMAGE_READER_FIRST_PASS_CLEAR_EN
    bus.hs_first_pass = 1'b1;
    run_pass("clear", 1'b0, 1'b0, 1'b1, 1'b0);
    bus.hs_first_pass = 1'b0;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
